id_ctrl_pipe: RTL and testbench

//  Parametrised decode-stage controller for the 5-stage MIPS32 pipeline. Decodes the IF/ID

---
 rtl/ctrl_pkg.sv | 62 ++++++
 rtl/id_decode.sv | 89 ++++++++
 rtl/id_ctrl_pipe.sv | 128 ++++++++++++
 tb/tb_id_ctrl_pipe.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the MIPS32 ID-stage controller
// ALU/compare op codes, opcode/funct/rt constants, FSM states and ex_ctrl bit positions.
package ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0, ALU_OR, ALU_ADD, ALU_XOR, ALU_SLL,
    ALU_SRL, ALU_SUB, ALU_SLT, ALU_MUL, ALU_NOR
  } alu_op_e;

  typedef enum logic [2:0] {
    CMP_GTZ = 3'd0, CMP_LTZ, CMP_GEZ, CMP_LEZ, CMP_EQ, CMP_NEQ
  } cmp_op_e;

  typedef enum logic [1:0] {ST_RUN, ST_LD_STALL, ST_MUL_WAIT} state_e;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_REGIMM   = 6'h01;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_BLEZ     = 6'h06;
  localparam logic [5:0] OP_BGTZ     = 6'h07;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_SLTI     = 6'h0A;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_LB       = 6'h20;
  localparam logic [5:0] OP_LH       = 6'h21;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_SB       = 6'h28;
  localparam logic [5:0] OP_SH       = 6'h29;
  localparam logic [5:0] OP_SW       = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A;
  localparam logic [5:0] F_MUL = 6'h02;

  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;

  // ex_ctrl_o = {R, RegWrite, MemWrite, MemRead, Half, Byte, JAL}
  localparam int CTRL_W        = 7;
  localparam int CTRL_R        = 6;
  localparam int CTRL_REGWRITE = 5;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_HALF     = 2;
  localparam int CTRL_BYTE     = 1;
  localparam int CTRL_JAL      = 0;

endpackage

// File: rtl/id_decode.sv
// rtl/id_decode.sv - combinational MIPS32 subset decoder
// Unknown encodings decode to known=0 with every control output zero.
module id_decode
  import ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 4,
  parameter int CMP_CTRL_W = 3
) (
  input  logic [5:0]            opcode,
  input  logic [4:0]            rt,
  input  logic [5:0]            funct,
  output logic                  known,
  output logic                  is_mul,
  output logic                  branch,
  output logic                  jump,
  output logic                  jr,
  output logic                  reads_rt,
  output logic [ALU_CTRL_W-1:0] alu_op,
  output logic [CMP_CTRL_W-1:0] cmp_op,
  output logic [CTRL_W-1:0]     ctrl
);

  alu_op_e alu;
  cmp_op_e cmp;
  logic    ok, mul, br, jmp, jreg, rd_rt, r, mw, mr, half, is_byte, jal, rw;

  always_comb begin
    ok = 1'b1; mul = 1'b0; br = 1'b0; jmp = 1'b0; jreg = 1'b0; rd_rt = 1'b0;
    r = 1'b0; mw = 1'b0; mr = 1'b0; half = 1'b0; is_byte = 1'b0; jal = 1'b0;
    alu = ALU_ADD; cmp = CMP_GTZ;
    case (opcode)
      OP_SPECIAL: begin
        r = 1'b1; rd_rt = 1'b1;
        case (funct)
          F_ADD: alu = ALU_ADD;
          F_SUB: alu = ALU_SUB;
          F_AND: alu = ALU_AND;
          F_OR:  alu = ALU_OR;
          F_XOR: alu = ALU_XOR;
          F_NOR: alu = ALU_NOR;
          F_SLT: alu = ALU_SLT;
          F_SLL: alu = ALU_SLL;
          F_SRL: alu = ALU_SRL;
          F_JR:  begin jmp = 1'b1; jreg = 1'b1; end
          default: ok = 1'b0;
        endcase
      end
      OP_SPECIAL2: begin
        r = 1'b1; rd_rt = 1'b1; mul = 1'b1; alu = ALU_MUL;
        ok = (funct == F_MUL);
      end
      OP_REGIMM: begin
        br = 1'b1; alu = ALU_SUB;
        cmp = (rt == RT_BGEZ) ? CMP_GEZ : CMP_LTZ;
        ok = (rt == RT_BLTZ) || (rt == RT_BGEZ);
      end
      OP_BEQ:  begin br = 1'b1; alu = ALU_SUB; cmp = CMP_EQ;  rd_rt = 1'b1; end
      OP_BNE:  begin br = 1'b1; alu = ALU_SUB; cmp = CMP_NEQ; rd_rt = 1'b1; end
      OP_BLEZ: begin br = 1'b1; alu = ALU_SUB; cmp = CMP_LEZ; end
      OP_BGTZ: begin br = 1'b1; alu = ALU_SUB; cmp = CMP_GTZ; end
      OP_J:    jmp = 1'b1;
      OP_JAL:  begin jmp = 1'b1; jal = 1'b1; end
      OP_ADDI: alu = ALU_ADD;
      OP_SLTI: alu = ALU_SLT;
      OP_ANDI: alu = ALU_AND;
      OP_ORI:  alu = ALU_OR;
      OP_XORI: alu = ALU_XOR;
      OP_LB:   begin mr = 1'b1; is_byte = 1'b1; end
      OP_LH:   begin mr = 1'b1; half = 1'b1; end
      OP_LW:   mr = 1'b1;
      OP_SB:   begin mw = 1'b1; is_byte = 1'b1; rd_rt = 1'b1; end
      OP_SH:   begin mw = 1'b1; half = 1'b1; rd_rt = 1'b1; end
      OP_SW:   begin mw = 1'b1; rd_rt = 1'b1; end
      default: ok = 1'b0;
    endcase
    rw = ~(mw | br | jmp) | jal;
  end

  assign known    = ok;
  assign is_mul   = ok & mul;
  assign branch   = ok & br;
  assign jump     = ok & jmp;
  assign jr       = ok & jreg;
  assign reads_rt = ok & rd_rt;
  assign alu_op   = ok ? ALU_CTRL_W'(alu) : '0;
  assign cmp_op   = (ok & br) ? CMP_CTRL_W'(cmp) : '0;
  assign ctrl     = ok ? {r, rw, mw, mr, half, is_byte, jal} : '0;

endmodule

// File: rtl/id_ctrl_pipe.sv
// rtl/id_ctrl_pipe.sv - ID-stage controller: hazard FSM, MUL counter, ID/EX register
// Optional CTRL_ILLEGAL_TRAP_EN: sticky illegal_o that halts the pipeline via hold_o.
module id_ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int ALU_CTRL_W  = 4,
  parameter int CMP_CTRL_W  = 3
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [31:0]           instr_i,
  input  logic                  instr_valid_i,
  input  logic                  flush_i,
  output logic                  id_branch_o,
  output logic                  id_jump_o,
  output logic                  id_jr_o,
  output logic [CMP_CTRL_W-1:0] id_cmp_ctrl_o,
  output logic                  hold_o,
  output logic                  ex_valid_o,
  output logic [ALU_CTRL_W-1:0] ex_alu_ctrl_o,
  output logic [CTRL_W-1:0]     ex_ctrl_o,
  output logic [4:0]            ex_rt_o,
  output logic                  mul_busy_o,
  output logic                  illegal_o
);

  localparam logic [3:0] MUL_INIT = 4'(MUL_LATENCY - 1);

  state_e                state, state_nxt;
  logic [3:0]            mul_cnt, cnt_nxt;
  logic                  fsm_hold, issue, load_use, id_gate;
  logic                  dec_known, dec_is_mul, dec_branch, dec_jump, dec_jr, dec_reads_rt;
  logic [ALU_CTRL_W-1:0] dec_alu;
  logic [CMP_CTRL_W-1:0] dec_cmp;
  logic [CTRL_W-1:0]     dec_ctrl;
  logic [4:0]            rs, rt;
  logic                  unused_imm;

  assign rs         = instr_i[25:21];
  assign rt         = instr_i[20:16];
  assign unused_imm = ^instr_i[15:6];

  id_decode #(.ALU_CTRL_W(ALU_CTRL_W), .CMP_CTRL_W(CMP_CTRL_W)) u_decode (
    .opcode   (instr_i[31:26]),
    .rt       (rt),
    .funct    (instr_i[5:0]),
    .known    (dec_known),
    .is_mul   (dec_is_mul),
    .branch   (dec_branch),
    .jump     (dec_jump),
    .jr       (dec_jr),
    .reads_rt (dec_reads_rt),
    .alu_op   (dec_alu),
    .cmp_op   (dec_cmp),
    .ctrl     (dec_ctrl)
  );

  // A flushed ID instruction never consumes the load result, so it cannot stall.
  assign load_use = instr_valid_i & ~flush_i & ex_valid_o & ex_ctrl_o[CTRL_MEMREAD]
                  & (ex_rt_o != 5'd0)
                  & ((ex_rt_o == rs) | (dec_reads_rt & (ex_rt_o == rt)));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = mul_cnt;
    fsm_hold  = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (load_use) begin
          fsm_hold  = 1'b1;
          state_nxt = ST_LD_STALL;
        end
      end
      ST_LD_STALL: state_nxt = ST_RUN;
      ST_MUL_WAIT: begin
        fsm_hold = instr_valid_i;
        cnt_nxt  = mul_cnt - 4'd1;
        if (mul_cnt == 4'd1) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
    hold_o = fsm_hold | illegal_o;
    issue  = instr_valid_i & ~flush_i & ~hold_o;
    if (issue & dec_is_mul) begin
      cnt_nxt   = MUL_INIT;
      state_nxt = (MUL_INIT != 4'd0) ? ST_MUL_WAIT : ST_RUN;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state         <= ST_RUN;
      mul_cnt       <= 4'd0;
      ex_valid_o    <= 1'b0;
      ex_alu_ctrl_o <= '0;
      ex_ctrl_o     <= '0;
      ex_rt_o       <= 5'd0;
    end else begin
      state         <= state_nxt;
      mul_cnt       <= cnt_nxt;
      ex_valid_o    <= issue & dec_known;
      ex_alu_ctrl_o <= (issue & dec_known) ? dec_alu : '0;
      ex_ctrl_o     <= (issue & dec_known) ? dec_ctrl : '0;
      ex_rt_o       <= (issue & dec_known) ? rt : 5'd0;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                   illegal_q <= 1'b0;
    else if (issue & ~dec_known)  illegal_q <= 1'b1;
  end
  assign illegal_o = illegal_q;
`else
  assign illegal_o = 1'b0;
`endif

  // Redirect decisions wait until the operands are stable (not held).
  assign id_gate       = instr_valid_i & ~hold_o;
  assign id_branch_o   = id_gate & dec_branch;
  assign id_jump_o     = id_gate & dec_jump;
  assign id_jr_o       = id_gate & dec_jr;
  assign id_cmp_ctrl_o = id_gate ? dec_cmp : '0;
  assign mul_busy_o    = (mul_cnt != 4'd0);

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// tb/tb_id_ctrl_pipe.sv - scoreboard bench for id_ctrl_pipe with a cycle-count reference model
module tb_id_ctrl_pipe;

  localparam int L = 4;

  logic        Clk, Rst_n, instr_valid_i, flush_i;
  logic [31:0] instr_i;
  logic        id_branch_o, id_jump_o, id_jr_o, hold_o, ex_valid_o, mul_busy_o, illegal_o;
  logic [2:0]  id_cmp_ctrl_o;
  logic [3:0]  ex_alu_ctrl_o;
  logic [6:0]  ex_ctrl_o;
  logic [4:0]  ex_rt_o;

  id_ctrl_pipe #(.MUL_LATENCY(L), .ALU_CTRL_W(4), .CMP_CTRL_W(3)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .flush_i(flush_i), .id_branch_o(id_branch_o), .id_jump_o(id_jump_o),
    .id_jr_o(id_jr_o), .id_cmp_ctrl_o(id_cmp_ctrl_o), .hold_o(hold_o),
    .ex_valid_o(ex_valid_o), .ex_alu_ctrl_o(ex_alu_ctrl_o), .ex_ctrl_o(ex_ctrl_o),
    .ex_rt_o(ex_rt_o), .mul_busy_o(mul_busy_o), .illegal_o(illegal_o)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic hold, br, jmp, jr;
    logic [2:0] cmp;
    logic busy, exv;
    logic [3:0] alu;
    logic [6:0] ctrl;
    logic [4:0] rt;
    logic ill;
  } obs_t;

  typedef struct packed {
    logic known, is_mul, branch, jump, jr, reads_rt;
    logic [2:0] cmp;
    logic [3:0] alu;
    logic [6:0] ctrl;
  } dec_t;

  obs_t sb[$];
  int   tq[$];
  int   npass = 0, ntotal = 0;

  // Reference state: the instruction sitting in EX, the cycle the last MUL issued, sticky trap.
  logic       m_exv, m_ill, mul_on, last_iss;
  logic [3:0] m_alu;
  logic [6:0] m_ctrl;
  logic [4:0] m_rt;
  int         cyc = 0, mul_cyc = 0;

  function automatic dec_t ref_dec(input logic [31:0] w);
    dec_t d;
    logic [5:0] op, fn;
    op = w[31:26]; fn = w[5:0];
    d = '0;
    d.known = 1'b1;
    case (op)
      6'h00: begin
        d.reads_rt = 1'b1; d.ctrl = 7'b1100000;
        case (fn)
          6'h20: d.alu = 4'd2;
          6'h22: d.alu = 4'd6;
          6'h24: d.alu = 4'd0;
          6'h25: d.alu = 4'd1;
          6'h26: d.alu = 4'd3;
          6'h27: d.alu = 4'd9;
          6'h2A: d.alu = 4'd7;
          6'h00: d.alu = 4'd4;
          6'h02: d.alu = 4'd5;
          6'h08: begin d.alu = 4'd2; d.jump = 1'b1; d.jr = 1'b1; d.ctrl = 7'b1000000; end
          default: d = '0;
        endcase
      end
      6'h1C: if (fn == 6'h02) begin
               d.is_mul = 1'b1; d.reads_rt = 1'b1; d.alu = 4'd8; d.ctrl = 7'b1100000;
             end else d = '0;
      6'h01: begin
        d.branch = 1'b1; d.alu = 4'd6;
        if (w[20:16] == 5'd0) d.cmp = 3'd1;
        else if (w[20:16] == 5'd1) d.cmp = 3'd2;
        else d = '0;
      end
      6'h04: begin d.branch = 1'b1; d.alu = 4'd6; d.cmp = 3'd4; d.reads_rt = 1'b1; end
      6'h05: begin d.branch = 1'b1; d.alu = 4'd6; d.cmp = 3'd5; d.reads_rt = 1'b1; end
      6'h06: begin d.branch = 1'b1; d.alu = 4'd6; d.cmp = 3'd3; end
      6'h07: begin d.branch = 1'b1; d.alu = 4'd6; d.cmp = 3'd0; end
      6'h02: begin d.jump = 1'b1; d.alu = 4'd2; end
      6'h03: begin d.jump = 1'b1; d.alu = 4'd2; d.ctrl = 7'b0100001; end
      6'h08: begin d.alu = 4'd2; d.ctrl = 7'b0100000; end
      6'h0A: begin d.alu = 4'd7; d.ctrl = 7'b0100000; end
      6'h0C: begin d.alu = 4'd0; d.ctrl = 7'b0100000; end
      6'h0D: begin d.alu = 4'd1; d.ctrl = 7'b0100000; end
      6'h0E: begin d.alu = 4'd3; d.ctrl = 7'b0100000; end
      6'h20: begin d.alu = 4'd2; d.ctrl = 7'b0101010; end
      6'h21: begin d.alu = 4'd2; d.ctrl = 7'b0101100; end
      6'h23: begin d.alu = 4'd2; d.ctrl = 7'b0101000; end
      6'h28: begin d.alu = 4'd2; d.ctrl = 7'b0010010; d.reads_rt = 1'b1; end
      6'h29: begin d.alu = 4'd2; d.ctrl = 7'b0010100; d.reads_rt = 1'b1; end
      6'h2B: begin d.alu = 4'd2; d.ctrl = 7'b0010000; d.reads_rt = 1'b1; end
      default: d = '0;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] rt_i(input logic [5:0] f, input logic [4:0] s, t, r);
    return {6'h00, s, t, r, 5'd0, f};
  endfunction

  function automatic logic [31:0] it_i(input logic [5:0] op, input logic [4:0] s, t,
                                       input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  task automatic model_clear();
    m_exv = 1'b0; m_alu = '0; m_ctrl = '0; m_rt = '0; m_ill = 1'b0; mul_on = 1'b0;
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic fl);
    dec_t d;
    obs_t e;
    logic busy, hazard, hold, iss;
    @(posedge Clk); #1;
    Rst_n = 1'b1; instr_valid_i = v; instr_i = ins; flush_i = fl;
    d = ref_dec(ins);
    busy   = mul_on && (cyc - mul_cyc >= 1) && (cyc - mul_cyc < L);
    hazard = m_exv && m_ctrl[3] && (m_rt != 5'd0) &&
             ((m_rt == ins[25:21]) || (d.reads_rt && m_rt == ins[20:16]));
    hold   = m_ill || (busy ? v : (v && !fl && hazard));
    e.hold = hold;
    e.br   = v && !hold && d.branch;
    e.jmp  = v && !hold && d.jump;
    e.jr   = v && !hold && d.jr;
    e.cmp  = (v && !hold) ? d.cmp : 3'd0;
    e.busy = busy;
    e.exv  = m_exv; e.alu = m_alu; e.ctrl = m_ctrl; e.rt = m_rt; e.ill = m_ill;
    sb.push_back(e); tq.push_back(cyc);
    iss = v && !fl && !hold;
    last_iss = iss;
    m_exv  = iss && d.known;
    m_alu  = m_exv ? d.alu : 4'd0;
    m_ctrl = m_exv ? d.ctrl : 7'd0;
    m_rt   = m_exv ? ins[20:16] : 5'd0;
    if (iss && d.is_mul) begin mul_on = 1'b1; mul_cyc = cyc; end
`ifdef CTRL_ILLEGAL_TRAP_EN
    if (iss && !d.known) m_ill = 1'b1;
`endif
    cyc++;
  endtask

  task automatic issue(input logic [31:0] ins);
    int n = 0;
    do begin
      step(1'b1, ins, 1'b0);
      n++;
    end while (!last_iss && n < 20);
    if (!last_iss) begin
      ntotal++;
      $display("FAIL issue_timeout instr=%h cycles=%0d required<20", ins, n);
    end
  endtask

  task automatic apply_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk); #1;
      Rst_n = 1'b0; instr_valid_i = 1'b0; flush_i = 1'b0; instr_i = '0;
      model_clear();
      sb.push_back('0); tq.push_back(cyc);
      cyc++;
    end
  endtask

  function automatic logic [31:0] rand_instr(input bit allow_bad);
    logic [4:0] a, b, c;
    logic [5:0] iops[5];
    logic [5:0] lops[3];
    logic [5:0] sops[3];
    logic [5:0] rfn[9];
    int k;
    iops = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E};
    lops = '{6'h20, 6'h21, 6'h23};
    sops = '{6'h28, 6'h29, 6'h2B};
    rfn  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02};
    a = 5'($urandom_range(0, 3)); b = 5'($urandom_range(0, 3)); c = 5'($urandom_range(0, 3));
    k = $urandom_range(0, allow_bad ? 14 : 12);
    case (k)
      0, 1:    return rt_i(rfn[$urandom_range(0, 8)], a, b, c);
      2:       return rt_i(6'h08, a, 5'd0, 5'd0);
      3:       return {6'h1C, a, b, c, 5'd0, 6'h02};
      4:       return it_i(iops[$urandom_range(0, 4)], a, b, 16'($urandom));
      5, 6, 7: return it_i(lops[$urandom_range(0, 2)], a, b, 16'($urandom));
      8:       return it_i(sops[$urandom_range(0, 2)], a, b, 16'($urandom));
      9:       return it_i(6'($urandom_range(4, 7)), a, b, 16'($urandom));
      10:      return it_i(6'h01, a, 5'($urandom_range(0, 1)), 16'($urandom));
      11:      return {6'($urandom_range(2, 3)), a, b, 16'($urandom)};
      12:      return it_i(6'h23, a, b, 16'd0);
      13:      return {6'h3F, a, b, 16'($urandom)};
      default: return rt_i(6'h01, a, b, c);
    endcase
  endfunction

  initial begin : monitor
    obs_t e, a;
    int   t;
    forever begin
      @(negedge Clk);
      if (sb.size() > 0) begin
        e = sb.pop_front(); t = tq.pop_front();
        a = {hold_o, id_branch_o, id_jump_o, id_jr_o, id_cmp_ctrl_o, mul_busy_o,
             ex_valid_o, ex_alu_ctrl_o, ex_ctrl_o, ex_rt_o, illegal_o};
        ntotal++;
        if (a === e) npass++;
        else $display("FAIL cycle_obs cyc=%0d got=%h required=%h", t, a, e);
      end
    end
  end

  initial begin : driver
    Rst_n = 1'b0; instr_valid_i = 1'b0; flush_i = 1'b0; instr_i = '0;
    model_clear(); last_iss = 1'b0;
    apply_reset(2);

    issue(it_i(6'h23, 5'd16, 5'd8, 16'd0));
    issue(rt_i(6'h20, 5'd8, 5'd10, 5'd9));
    step(1'b0, 32'h0, 1'b0);

    issue({6'h1C, 5'd12, 5'd13, 5'd11, 5'd0, 6'h02});
    issue(it_i(6'h08, 5'd11, 5'd14, 16'd5));
    issue({6'h1C, 5'd12, 5'd13, 5'd11, 5'd0, 6'h02});
    issue({6'h1C, 5'd11, 5'd13, 5'd15, 5'd0, 6'h02});
    step(1'b0, 32'h0, 1'b0);

    issue(it_i(6'h23, 5'd16, 5'd8, 16'd4));
    step(1'b1, it_i(6'h04, 5'd8, 5'd9, 16'd3), 1'b1);
    issue(it_i(6'h08, 5'd8, 5'd9, 16'd1));

    issue({6'h03, 26'h0000040});
    issue(rt_i(6'h08, 5'd31, 5'd0, 5'd0));
    issue(it_i(6'h01, 5'd3, 5'd1, 16'd8));
    issue(it_i(6'h07, 5'd3, 5'd0, 16'd8));

    issue({6'h1C, 5'd12, 5'd13, 5'd11, 5'd0, 6'h02});
    step(1'b1, it_i(6'h08, 5'd1, 5'd2, 16'd1), 1'b0);
    apply_reset(2);
    issue(it_i(6'h08, 5'd1, 5'd2, 16'd1));

    for (int i = 0; i < 400; i++) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
      step($urandom_range(0, 9) != 0, rand_instr(1'b0), $urandom_range(0, 9) == 0);
`else
      step($urandom_range(0, 9) != 0, rand_instr(1'b1), $urandom_range(0, 9) == 0);
`endif
    end

    step(1'b0, 32'h0, 1'b0);
    step(1'b1, {6'h3F, 26'h0}, 1'b0);
    step(1'b1, it_i(6'h08, 5'd1, 5'd2, 16'd1), 1'b0);
    step(1'b1, it_i(6'h08, 5'd1, 5'd2, 16'd1), 1'b0);
    step(1'b0, 32'h0, 1'b0);

    repeat (3) @(negedge Clk);
    ntotal++;
    if (sb.size() == 0) npass++;
    else $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
